// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : Oversampled UART receiver (1 start, d_bits data LSB first,
//            STOP_BITS stop, no parity) with framing-error flag.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int DATA_BITS   = 8,
  parameter int STOP_BITS   = 1,
  parameter int OVRSAMPLING = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_tick,
  input  logic                 rx,
  input  logic [3:0]           d_bits,
  output logic [DATA_BITS-1:0] dout,
  output logic                 rx_done,
  output logic                 frame_err
);

  localparam int c_S_MAX = ((STOP_BITS * OVRSAMPLING > OVRSAMPLING) ?
                            STOP_BITS * OVRSAMPLING : OVRSAMPLING) - 1;
  localparam int c_S_W   = $clog2(c_S_MAX + 1);
  localparam int c_E_W   = $clog2(DATA_BITS + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t               r_state, w_state_nx;
  logic [c_S_W-1:0]     r_s, w_s_nx;
  logic [3:0]           r_n, w_n_nx;
  logic [c_E_W-1:0]     r_eff, w_eff_nx, w_eff_in;
  logic [DATA_BITS-1:0] r_shreg, w_shreg_nx;
  logic [DATA_BITS:0]   w_shift_in;
  logic                 r_err, w_err_nx;
  logic                 w_done, w_mid, w_last;
  logic                 r_rx_meta, r_rx_s;

  // Out-of-range or zero widths fall back to the full data width.
  always_comb begin
    if (d_bits == 4'd0 || int'(d_bits) > DATA_BITS)
      w_eff_in = c_E_W'(DATA_BITS);
    else
      w_eff_in = c_E_W'(d_bits);
  end

  assign w_shift_in = {r_rx_s, r_shreg};
  assign w_last     = (int'(r_n) == int'(r_eff) - 1);

  always_comb begin
    w_state_nx = r_state;
    w_s_nx     = r_s;
    w_n_nx     = r_n;
    w_eff_nx   = r_eff;
    w_shreg_nx = r_shreg;
    w_err_nx   = r_err;
    w_done     = 1'b0;
    w_mid      = 1'b0;
    for (int k = 1; k <= STOP_BITS; k++)
      if (int'(r_s) == k * OVRSAMPLING - 1) w_mid = 1'b1;

    case (r_state)
      ST_IDLE: begin
        if (!r_rx_s) begin
          w_state_nx = ST_START;
          w_s_nx     = '0;
          w_eff_nx   = w_eff_in;
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (int'(r_s) == OVRSAMPLING / 2 - 1) begin
            w_s_nx = '0;
            if (!r_rx_s) begin
              w_state_nx = ST_DATA;
              w_n_nx     = '0;
            end else begin
              w_state_nx = ST_IDLE;
            end
          end else begin
            w_s_nx = r_s + c_S_W'(1);
          end
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (int'(r_s) == OVRSAMPLING - 1) begin
            w_s_nx     = '0;
            w_shreg_nx = w_shift_in[DATA_BITS:1];
            if (w_last) begin
              w_state_nx = ST_STOP;
              w_err_nx   = 1'b0;
            end else begin
              w_n_nx = r_n + 4'd1;
            end
          end else begin
            w_s_nx = r_s + c_S_W'(1);
          end
        end
      end
      ST_STOP: begin
        if (s_tick) begin
          if (w_mid && !r_rx_s) w_err_nx = 1'b1;
          // Finishing mid-stop-bit leaves half a bit to spot the next start.
          if (int'(r_s) == STOP_BITS * OVRSAMPLING - 1) begin
            w_state_nx = ST_IDLE;
            w_s_nx     = '0;
            w_done     = 1'b1;
          end else begin
            w_s_nx = r_s + c_S_W'(1);
          end
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_state   <= ST_IDLE;
      r_s       <= '0;
      r_n       <= '0;
      r_eff     <= '0;
      r_shreg   <= '0;
      r_err     <= 1'b0;
      dout      <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
      r_state   <= w_state_nx;
      r_s       <= w_s_nx;
      r_n       <= w_n_nx;
      r_eff     <= w_eff_nx;
      r_shreg   <= w_shreg_nx;
      r_err     <= w_err_nx;
      rx_done   <= w_done;
      if (w_done) begin
        dout      <= r_shreg >> (DATA_BITS - int'(r_eff));
        frame_err <= w_err_nx;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver that deserialises the asynchronous rx line into parallel data. It is the receive-side counterpart of the UART transmitter and shares its baud-rate generator tick (s_tick, OVRSAMPLING ticks per bit). Frame format is 1 start bit, d_bits data bits sent LSB first, then STOP_BITS stop bits, with no parity. On each frame it delivers a one-cycle done pulse with the received data and a framing-error flag to the UART core / FIFO.

Parameters:
DATA_BITS, 8, maximum data bits per frame; width of dout.
STOP_BITS, 1, number of stop bits (1 or 2).
OVRSAMPLING, 16, s_tick pulses per bit period; must be even and at least 4.

Ports:
clk  input  1  system clock.
reset  input  1  asynchronous, active-high reset.
s_tick  input  1  oversampling tick from the baud generator; one clk wide.
rx  input  1  asynchronous serial input; idles high.
d_bits  input  4  data bits per frame; must be static during a frame.
dout  output  DATA_BITS  received data, right-aligned, upper bits zero.
rx_done  output  1  one-cycle pulse; frame complete, dout and frame_err valid.
frame_err  output  1  high when any stop-bit sample was low in the last frame.

Behaviour:
- Reset (async) values: state idle, all counters 0, shift reg 0, dout 0, rx_done 0, frame_err 0, both synchroniser flops 1.
- rx passes through a 2-flop synchroniser (rx_s). All FSM decisions use rx_s only.
- Tick counter s is sized for max(OVRSAMPLING, STOP_BITS*OVRSAMPLING)-1. Bit counter n is 4 bits.
- Effective bit count: eff = DATA_BITS if d_bits==0 or d_bits>DATA_BITS, else d_bits. eff is latched on leaving idle.
- States:
  - idle: when rx_s==0, go to start with s=0. s_tick is not required for this transition.
  - start: on each s_tick, s++. When s==OVRSAMPLING/2-1 on a tick:
    - if rx_s==0, go to data with s=0, n=0 (now aligned to mid-bit);
    - else treat as a glitch/false start: go to idle, no rx_done.
  - data: on each s_tick, s++. When s==OVRSAMPLING-1 on a tick: s=0, shift reg = {rx_s, shreg[DATA_BITS-1:1]}. If n==eff-1, go to stop; else n++.
  - stop: on each s_tick, s++. At each stop-bit midpoint (s==k*OVRSAMPLING-1 for k=1..STOP_BITS), sample rx_s; any low sample sets an internal err bit.
    - Err is cleared on entry to stop.
    - At s==STOP_BITS*OVRSAMPLING-1 on a tick, go to idle.
- Completion: on the clk following that final stop tick, the following hold for exactly one cycle:
  - rx_done=1;
  - dout = shreg >> (DATA_BITS-eff);
  - frame_err = err (including the final sample).
- dout and frame_err are registered and hold until the next rx_done. They update even when framing fails.
- Frame ends at mid-last-stop-bit, so a start bit immediately following is detected with no loss.
- s_tick is ignored in idle. Ticks arriving on the same cycle as a state transition count in the new state only as specified above; no tick is double-counted.
- A rx_s low during stop sets err only; it does not abort the frame.
- Reset mid-frame: immediate return to idle with reset values. The partial frame is discarded; no rx_done.
- Latency: rx falling edge to rx_done is about 2 clk (sync) + (0.5 + eff + STOP_BITS - 0.5 + ...) bit periods. Precisely: OVRSAMPLING/2 + eff*OVRSAMPLING + STOP_BITS*OVRSAMPLING ticks after detection, plus 1 clk.

Test Plan:
- 8N1, OVRSAMPLING=16, s_tick every 4 clk, frame 0xA5 -> one rx_done pulse, dout=0xA5, frame_err=0, rx_done 1 clk wide.
- d_bits=7, frame 0x55 sent as 7 bits -> dout=0x55, bit 7 of dout is 0. d_bits=0 then 0xC3 -> treated as 8 bits, dout=0xC3.
- rx low pulse of 5 ticks in idle -> FSM returns to idle at tick 7, no rx_done, dout unchanged.
- Frame 0x3C with stop bit driven low -> rx_done=1, dout=0x3C, frame_err=1. Next clean frame 0x81 -> frame_err=0.
- Back-to-back frames 0x01, 0xFE, 0x7F with zero idle time between them -> three rx_done pulses with dout matching in order.
- Reset asserted during data bit 3 of 0xAA, then 0x12 sent -> no rx_done for the partial frame; outputs 0 after reset; one rx_done with dout=0x12.
